// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state encodings,
// default protection bits and a saturating 8-bit increment.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} rd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational base/mask address decoder. Lowest matching slave index
// wins on overlapping windows; o_hit low means the address is unmapped.
module axi_lite_addr_decode #(
  parameter int                            NUM_SLAVES = 3,
  parameter int                            ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = '0,
  parameter int                            SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_hit
);

  // scan from the top so the lowest matching index is the last one written
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        o_sel = SEL_W'(i);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_xbar_1xn.sv
// AXI4-Lite 1-master to N-slave crossbar with independent read and write
// FSMs and local DECERR for unmapped addresses.
// Optional: define AXI_XBAR_ERR_CNT_EN to add error counters and err_irq.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order, same cycle allowed)
// W_FWD  | forwarding held AW/W to the selected slave
// W_RESP | passing the selected slave's B back to the master
// W_ERR  | returning local DECERR on B
// R_IDLE | accepting AR
// R_FWD  | forwarding AR to the selected slave
// R_RESP | passing the selected slave's R back to the master
// R_ERR  | returning local DECERR with zero data on R
module axi_lite_xbar_1xn
  import axi_lite_pkg::*;
#(
  parameter int                            NUM_SLAVES = 3,
  parameter int                            ADDR_W     = 32,
  parameter int                            DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {3{32'hF000_0000}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [NUM_SLAVES*ADDR_W-1:0] m_awaddr,
  output logic [NUM_SLAVES-1:0]        m_awvalid,
  input  logic [NUM_SLAVES-1:0]        m_awready,
  output logic [NUM_SLAVES*3-1:0]      m_awprot,
  output logic [NUM_SLAVES*DATA_W-1:0] m_wdata,
  output logic [NUM_SLAVES*DATA_W/8-1:0] m_wstrb,
  output logic [NUM_SLAVES-1:0]        m_wvalid,
  input  logic [NUM_SLAVES-1:0]        m_wready,
  input  logic [NUM_SLAVES*2-1:0]      m_bresp,
  input  logic [NUM_SLAVES-1:0]        m_bvalid,
  output logic [NUM_SLAVES-1:0]        m_bready,
  output logic [NUM_SLAVES*ADDR_W-1:0] m_araddr,
  output logic [NUM_SLAVES-1:0]        m_arvalid,
  input  logic [NUM_SLAVES-1:0]        m_arready,
  output logic [NUM_SLAVES*3-1:0]      m_arprot,
  input  logic [NUM_SLAVES*DATA_W-1:0] m_rdata,
  input  logic [NUM_SLAVES*2-1:0]      m_rresp,
  input  logic [NUM_SLAVES-1:0]        m_rvalid,
  output logic [NUM_SLAVES-1:0]        m_rready
`ifdef AXI_XBAR_ERR_CNT_EN
  ,
  output logic [7:0]                   wr_err_cnt,
  output logic [7:0]                   rd_err_cnt,
  output logic                         err_irq
`endif
);

  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_W / 8;

  wr_state_e           r_wstate;
  rd_state_e           r_rstate;
  logic                r_aw_held, r_w_held, r_aw_done, r_w_done;
  logic                r_awready, r_wready, r_arready;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [SEL_W-1:0]    r_wsel, r_rsel;

  logic                w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_b_hs;
  logic                w_m_aw_hs, w_m_w_hs, w_m_ar_hs, w_ar_hs, w_r_hs;
  logic [ADDR_W-1:0]   w_wr_dec_addr;
  logic [SEL_W-1:0]    w_wr_sel, w_rd_sel;
  logic                w_wr_hit, w_rd_hit;

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_arready = r_arready;

  assign w_aw_hs   = s_awvalid & r_awready;
  assign w_w_hs    = s_wvalid & r_wready;
  assign w_aw_have = r_aw_held | w_aw_hs;
  assign w_w_have  = r_w_held | w_w_hs;
  assign w_b_hs    = s_bvalid & s_bready;
  assign w_m_aw_hs = |(m_awvalid & m_awready);
  assign w_m_w_hs  = |(m_wvalid & m_wready);
  assign w_ar_hs   = s_arvalid & r_arready;
  assign w_m_ar_hs = |(m_arvalid & m_arready);
  assign w_r_hs    = s_rvalid & s_rready;

  // decode the address arriving this cycle so forwarding starts next cycle
  assign w_wr_dec_addr = r_aw_held ? r_awaddr : s_awaddr;

  axi_lite_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK), .SEL_W(SEL_W)
  ) u_wr_dec (.i_addr(w_wr_dec_addr), .o_sel(w_wr_sel), .o_hit(w_wr_hit));

  axi_lite_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK), .SEL_W(SEL_W)
  ) u_rd_dec (.i_addr(s_araddr), .o_sel(w_rd_sel), .o_hit(w_rd_hit));

  assign m_awaddr = {NUM_SLAVES{r_awaddr}};
  assign m_wdata  = {NUM_SLAVES{r_wdata}};
  assign m_wstrb  = {NUM_SLAVES{r_wstrb}};
  assign m_araddr = {NUM_SLAVES{r_araddr}};
  assign m_awprot = {NUM_SLAVES{PROT_DEFAULT}};
  assign m_arprot = {NUM_SLAVES{PROT_DEFAULT}};

  // write FSM: latch AW/W independently, forward, then return B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wsel    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) r_awaddr <= s_awaddr;
          if (w_w_hs) begin
            r_wdata <= s_wdata;
            r_wstrb <= s_wstrb;
          end
          if (w_aw_have && w_w_have) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wsel    <= w_wr_sel;
            r_wstate  <= w_wr_hit ? W_FWD : W_ERR;
          end else begin
            r_aw_held <= w_aw_have;
            r_w_held  <= w_w_have;
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
          end
        end
        W_FWD: begin
          if (w_m_aw_hs) r_aw_done <= 1'b1;
          if (w_m_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done | w_m_aw_hs) && (r_w_done | w_m_w_hs)) r_wstate <= W_RESP;
        end
        default: begin
          if (w_b_hs) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  // read FSM: accept AR, forward, then return R
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_araddr  <= '0;
      r_rsel    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_araddr  <= s_araddr;
            r_rsel    <= w_rd_sel;
            r_arready <= 1'b0;
            r_rstate  <= w_rd_hit ? R_FWD : R_ERR;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_FWD: if (w_m_ar_hs) r_rstate <= R_RESP;
        default: begin
          if (w_r_hs) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
          end
        end
      endcase
    end
  end

  // steer valids/readies to the selected slave only and mirror its response
  always_comb begin
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    m_arvalid = '0;
    m_rready  = '0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    case (r_wstate)
      W_FWD: begin
        m_awvalid[r_wsel] = ~r_aw_done;
        m_wvalid[r_wsel]  = ~r_w_done;
      end
      W_RESP: begin
        s_bvalid         = m_bvalid[r_wsel];
        s_bresp          = m_bresp[int'(r_wsel)*2 +: 2];
        m_bready[r_wsel] = s_bready;
      end
      W_ERR: begin
        s_bvalid = 1'b1;
        s_bresp  = RESP_DECERR;
      end
      default: ;
    endcase
    case (r_rstate)
      R_FWD: m_arvalid[r_rsel] = 1'b1;
      R_RESP: begin
        s_rvalid         = m_rvalid[r_rsel];
        s_rdata          = m_rdata[int'(r_rsel)*DATA_W +: DATA_W];
        s_rresp          = m_rresp[int'(r_rsel)*2 +: 2];
        m_rready[r_rsel] = s_rready;
      end
      R_ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

`ifdef AXI_XBAR_ERR_CNT_EN
  logic [7:0] r_wr_err_cnt, r_rd_err_cnt;
  logic       r_err_irq;
  logic [7:0] w_wr_err_nxt, w_rd_err_nxt;

  assign w_wr_err_nxt = (w_b_hs && s_bresp != RESP_OKAY) ? sat_inc8(r_wr_err_cnt) : r_wr_err_cnt;
  assign w_rd_err_nxt = (w_r_hs && s_rresp != RESP_OKAY) ? sat_inc8(r_rd_err_cnt) : r_rd_err_cnt;

  // error counters; irq follows the next-state counts so it tracks them exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_err_cnt <= '0;
      r_rd_err_cnt <= '0;
      r_err_irq    <= 1'b0;
    end else begin
      r_wr_err_cnt <= w_wr_err_nxt;
      r_rd_err_cnt <= w_rd_err_nxt;
      r_err_irq    <= |{w_wr_err_nxt, w_rd_err_nxt};
    end
  end

  assign wr_err_cnt = r_wr_err_cnt;
  assign rd_err_cnt = r_rd_err_cnt;
  assign err_irq    = r_err_irq;
`endif

endmodule

// File: tb/tb_axi_lite_xbar_1xn.sv
// Randomised self-checking bench for axi_lite_xbar_1xn with bench-side
// slave memories and a reference decode/memory model.
module tb_axi_lite_xbar_1xn;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {3{32'hF000_0000}};

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic [NS*AW-1:0] m_awaddr, m_araddr;
  logic [NS-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NS-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NS*3-1:0] m_awprot, m_arprot;
  logic [NS*DW-1:0] m_wdata, m_rdata;
  logic [NS*SW-1:0] m_wstrb;
  logic [NS*2-1:0] m_bresp, m_rresp;
`ifdef AXI_XBAR_ERR_CNT_EN
  logic [7:0] wr_err_cnt, rd_err_cnt;
  logic err_irq;
`endif

  axi_lite_xbar_1xn #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef AXI_XBAR_ERR_CNT_EN
    , .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt), .err_irq(err_irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [34:0]];
  int exp_wr_err = 0;
  int exp_rd_err = 0;

  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) return i;
    return -1;
  endfunction

  function automatic logic [1:0] slv_resp(input logic [31:0] a);
    return (a[5:2] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input int sel, input logic [31:0] a);
    logic [34:0] k;
    k = {3'(sel), a};
    return ref_mem.exists(k) ? ref_mem[k] : ~a;
  endfunction

  // ---------------- slave models ----------------
  logic [31:0] slv_mem [logic [34:0]];
  bit slv_stall = 0;
  int rd_wait_force = -1;
  int exp_wsel = -1;
  int exp_rsel = -1;
  logic [31:0] cur_waddr, cur_wdata, cur_raddr;
  logic [3:0]  cur_wstrb;
  int stray = 0;
  bit aw_seen [NS], w_seen [NS], b_pend [NS], r_pend [NS];
  int b_wait [NS], r_wait [NS];
  logic [31:0] sw_addr [NS], sw_data [NS], sr_addr [NS];
  logic [3:0]  sw_strb [NS];

  function automatic logic [31:0] slv_read(input int i, input logic [31:0] a);
    logic [34:0] k;
    k = {3'(i), a};
    return slv_mem.exists(k) ? slv_mem[k] : ~a;
  endfunction

  always begin
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      m_awready[i] = !slv_stall && !aw_seen[i] && 1'($urandom_range(0, 1));
      m_wready[i]  = !slv_stall && !w_seen[i] && 1'($urandom_range(0, 1));
      m_arready[i] = !slv_stall && !r_pend[i] && 1'($urandom_range(0, 1));
      m_bvalid[i]  = b_pend[i] && (b_wait[i] == 0);
      m_bresp[i*2 +: 2] = slv_resp(sw_addr[i]);
      m_rvalid[i]  = r_pend[i] && (r_wait[i] == 0);
      m_rdata[i*DW +: DW] = slv_read(i, sr_addr[i]);
      m_rresp[i*2 +: 2] = slv_resp(sr_addr[i]);
    end
    #4;
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        aw_seen[i] = 0; w_seen[i] = 0; b_pend[i] = 0; r_pend[i] = 0;
      end else begin
        if ((m_awvalid[i] || m_wvalid[i] || m_bready[i]) && i != exp_wsel) stray++;
        if ((m_arvalid[i] || m_rready[i]) && i != exp_rsel) stray++;
        if (m_awvalid[i] && m_awready[i]) begin
          check_eq("slv_aw_sel", i, exp_wsel);
          check_eq("slv_awaddr", m_awaddr[i*AW +: AW], cur_waddr);
          aw_seen[i] = 1; sw_addr[i] = m_awaddr[i*AW +: AW];
        end
        if (m_wvalid[i] && m_wready[i]) begin
          check_eq("slv_wdata", m_wdata[i*DW +: DW], cur_wdata);
          check_eq("slv_wstrb", m_wstrb[i*SW +: SW], cur_wstrb);
          w_seen[i] = 1; sw_data[i] = m_wdata[i*DW +: DW]; sw_strb[i] = m_wstrb[i*SW +: SW];
        end
        if (m_bvalid[i] && m_bready[i]) begin
          b_pend[i] = 0; aw_seen[i] = 0; w_seen[i] = 0;
        end else if (b_pend[i] && b_wait[i] > 0) begin
          b_wait[i]--;
        end else if (!b_pend[i] && aw_seen[i] && w_seen[i]) begin
          slv_mem[{3'(i), sw_addr[i]}] = merge(slv_read(i, sw_addr[i]), sw_data[i], sw_strb[i]);
          b_pend[i] = 1; b_wait[i] = $urandom_range(0, 3);
        end
        if (m_arvalid[i] && m_arready[i]) begin
          check_eq("slv_ar_sel", i, exp_rsel);
          check_eq("slv_araddr", m_araddr[i*AW +: AW], cur_raddr);
          r_pend[i] = 1; sr_addr[i] = m_araddr[i*AW +: AW];
          r_wait[i] = (rd_wait_force >= 0) ? rd_wait_force : $urandom_range(0, 4);
        end else if (m_rvalid[i] && m_rready[i]) begin
          r_pend[i] = 0;
        end else if (r_pend[i] && r_wait[i] > 0) begin
          r_wait[i]--;
        end
      end
    end
  end

  // ---------------- master tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_dly, input int w_dly);
    int sel, cyc;
    bit awd, wd, bd;
    logic [1:0] eresp;
    sel = ref_sel(a); cyc = 0; awd = 0; wd = 0; bd = 0;
    eresp = (sel < 0) ? 2'b11 : slv_resp(a);
    exp_wsel = sel; cur_waddr = a; cur_wdata = d; cur_wstrb = st;
    while (!bd && cyc < 200) begin
      @(negedge clk);
      s_awaddr = a; s_wdata = d; s_wstrb = st;
      s_awvalid = !awd && (cyc >= aw_dly);
      s_wvalid  = !wd && (cyc >= w_dly);
      s_bready  = 1'($urandom_range(0, 1));
      #4;
      if (s_awvalid && s_awready) awd = 1;
      if (s_wvalid && s_wready) wd = 1;
      if (s_bvalid && s_bready) begin
        bd = 1;
        check_eq("bresp", s_bresp, eresp);
      end
      cyc++;
    end
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; exp_wsel = -1;
    check_eq("wr_done", bd, 1);
    if (sel >= 0) ref_mem[{3'(sel), a}] = merge(ref_read(sel, a), d, st);
    if (eresp != 2'b00 && exp_wr_err < 255) exp_wr_err++;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int sel, cyc, rv_seen;
    bit ard, rd, pend;
    logic [31:0] ed, pdata;
    logic [1:0] er;
    sel = ref_sel(a); cyc = 0; rv_seen = 0; ard = 0; rd = 0; pend = 0; pdata = '0;
    ed = (sel < 0) ? 32'h0 : ref_read(sel, a);
    er = (sel < 0) ? 2'b11 : slv_resp(a);
    exp_rsel = sel; cur_raddr = a;
    while (!rd && cyc < 200) begin
      @(negedge clk);
      s_araddr  = a;
      s_arvalid = !ard;
      s_rready  = (hold > 0) ? (rv_seen >= hold) : 1'($urandom_range(0, 1));
      #4;
      if (s_arvalid && s_arready) ard = 1;
      if (pend) begin
        check_eq("rvalid_held", s_rvalid, 1);
        check_eq("rdata_stable", s_rdata, pdata);
      end
      if (s_rvalid) begin
        rv_seen++;
        if (s_rready) begin
          rd = 1;
          check_eq("rdata", s_rdata, ed);
          check_eq("rresp", s_rresp, er);
        end else begin
          pend = 1; pdata = s_rdata;
        end
      end else begin
        pend = 0;
      end
      cyc++;
    end
    @(negedge clk);
    s_arvalid = 0; s_rready = 0; exp_rsel = -1;
    check_eq("rd_done", rd, 1);
    if (hold > 0) check_eq("rready_hold", rv_seen, hold + 1);
    if (er != 2'b00 && exp_rd_err < 255) exp_rd_err++;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 4);
    if (r < NS) return BASE[r*AW +: AW] | (32'($urandom_range(0, 63)) << 2);
    return {4'($urandom_range(3, 15)), 28'($urandom)} & 32'hFFFF_FFFC;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit a_d, w_d;
    logic [31:0] wa, ra, wd;
    int op;
    rst = 1; s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0;
    repeat (3) @(negedge clk);
    #4;
    check_eq("rst_ready", {s_awready, s_wready, s_arready}, 0);
    check_eq("rst_svalid", {s_bvalid, s_rvalid}, 0);
    check_eq("rst_mvalid", {m_awvalid, m_wvalid, m_arvalid}, 0);
    check_eq("rst_awaddr", m_awaddr[AW-1:0], 0);
    @(negedge clk) rst = 0;
    repeat (2) @(negedge clk);
    #4;
    check_eq("idle_ready", {s_awready, s_wready, s_arready}, 3'b111);

    do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_write(32'h2000_0010, 32'hCAFE_0123, 4'hF, 3, 0);
    do_write(32'h0000_0008, 32'h1234_5678, 4'hF, 0, 0);
    rd_wait_force = 4;
    do_read(32'h0000_0008, 2);
    rd_wait_force = -1;
    do_read(32'h3000_0000, 0);
    do_write(32'h3000_0000, 32'h5555_AAAA, 4'hF, 0, 0);
    check_eq("decerr_no_fwd", stray, 0);

    fork
      do_write(32'h1000_0020, 32'h0BAD_F00D, 4'h5, 1, 0);
      do_read(32'h2000_0010, 0);
    join

    // reset while a write is stuck in forwarding
    slv_stall = 1; exp_wsel = 1; cur_waddr = 32'h1000_0040; cur_wdata = 32'h7777_0000; cur_wstrb = 4'hF;
    a_d = 0; w_d = 0;
    for (int c = 0; c < 10 && !(a_d && w_d); c++) begin
      @(negedge clk);
      s_awaddr = 32'h1000_0040; s_wdata = 32'h7777_0000; s_wstrb = 4'hF;
      s_awvalid = !a_d; s_wvalid = !w_d;
      #4;
      if (s_awvalid && s_awready) a_d = 1;
      if (s_wvalid && s_wready) w_d = 1;
    end
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    #4;
    check_eq("fwd_before_rst", m_awvalid, 3'b010);
    @(negedge clk) rst = 1;
    #4;
    check_eq("midrst_mvalid", {m_awvalid, m_wvalid, m_arvalid}, 0);
    check_eq("midrst_svalid", {s_bvalid, s_rvalid}, 0);
    @(negedge clk);
    rst = 0; slv_stall = 0; exp_wsel = -1; exp_wr_err = 0; exp_rd_err = 0;
    repeat (2) @(negedge clk);
    #4;
    check_eq("post_rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
    do_write(32'h1000_0040, 32'h7777_0001, 4'hF, 0, 0);
    do_read(32'h1000_0040, 0);

    for (int n = 0; n < 40; n++) begin
      wa = rand_addr(); ra = rand_addr(); wd = $urandom;
      if (ra == wa) ra = ra ^ 32'h40;
      op = $urandom_range(0, 2);
      if (op == 0) do_write(wa, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op == 1) do_read(ra, 0);
      else fork
        do_write(wa, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        do_read(ra, 0);
      join
    end

`ifdef AXI_XBAR_ERR_CNT_EN
    check_eq("wr_err_cnt_rand", wr_err_cnt, exp_wr_err);
    check_eq("rd_err_cnt_rand", rd_err_cnt, exp_rd_err);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    exp_wr_err = 0; exp_rd_err = 0;
    #4;
    check_eq("err_irq_rst", err_irq, 0);
    for (int k = 0; k < 3; k++) do_read(32'h3000_0000 + 32'(k*4), 0);
    do_write(32'h4000_0000, 32'h1, 4'hF, 0, 0);
    check_eq("rd_err_cnt_3", rd_err_cnt, 3);
    check_eq("wr_err_cnt_1", wr_err_cnt, 1);
    check_eq("err_irq_set", err_irq, 1);
    for (int k = 0; k < 300; k++) do_read(32'hE000_0000 + 32'(k*4), 0);
    check_eq("rd_err_cnt_sat", rd_err_cnt, 255);
    check_eq("rd_err_cnt_model", rd_err_cnt, exp_rd_err);
`endif

    check_eq("stray_valids", stray, 0);
    check_eq("prot_zero", {m_awprot, m_arprot}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
